// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel compositor: play-window bounds,
// fade/layer enums, per-pixel pipeline flags and the colour palette.
package pixel_pkg;

    localparam logic [9:0] WIN_X_MIN = 10'd203;
    localparam logic [9:0] WIN_X_MAX = 10'd435;
    localparam logic [9:0] WIN_Y_MIN = 10'd152;
    localparam logic [9:0] WIN_Y_MAX = 10'd327;

    typedef enum logic [1:0] {
        SHOW_START = 2'd0,
        FADE_OUT   = 2'd1,
        FADE_IN    = 2'd2,
        SHOW_GAME  = 2'd3
    } fade_state_t;

    typedef enum logic {
        START = 1'b0,
        GAME  = 1'b1
    } layer_sel_t;

    typedef struct packed {
        logic       in_win;
        logic       cov_bar;
        logic       cov_kirby;
        logic       cov_star;
        logic       cov_enemy;
        layer_sel_t sel;
        logic [4:0] bright;
    } pix_flags_t;

    // Index 15 first: entry n sits at PALETTE[n].
    localparam logic [15:0][23:0] PALETTE = {
        24'h202020, 24'hF8A0C8, 24'h008040, 24'h804000,
        24'hC0C0C0, 24'h40C0FF, 24'hFF8040, 24'h808080,
        24'h00FFFF, 24'hFF00FF, 24'hFFFF00, 24'h0000FF,
        24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'h000000
    };

    function automatic logic [7:0] fade_chan(input logic [7:0] c, input logic [4:0] b, input int shift);
        logic [11:0] prod;
        prod = {4'd0, c} * {7'd0, b};
        return 8'(prod >> shift);
    endfunction

endpackage

// File: rtl/palette_lut.sv
// Palette lookup: 4-bit code to 24-bit RGB, registered. Forms the compose
// stage of the compositor pipeline.
module palette_lut
    import pixel_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  code,
    output logic [23:0] rgb
);

    logic [23:0] rgb_d;
    logic [23:0] rgb_q;

    // Combinational palette read.
    always_comb begin
        rgb_d = PALETTE[code];
    end

    // Compose register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/pixel_compositor.sv
// Layer compositor: registers sprite-ROM addresses, resolves priority and
// transparency on returned codes, applies the frame fade and drives RGB.
module pixel_compositor
    import pixel_pkg::*;
#(
    parameter int ROM_LAT     = 2,
    parameter int FADE_FRAMES = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_tick,
    input  logic        game_start,
    input  logic [16:0] backindex,
    input  logic [17:0] areaindex,
    input  logic [17:0] kirbyindex,
    input  logic [16:0] starindex,
    input  logic [17:0] enemyindex,
    input  logic [16:0] barindex,
    input  logic [16:0] gamestartindex,
    output logic [16:0] back_addr,
    output logic [17:0] area_addr,
    output logic [17:0] kirby_addr,
    output logic [16:0] star_addr,
    output logic [17:0] enemy_addr,
    output logic [16:0] bar_addr,
    output logic [16:0] start_addr,
    input  logic [3:0]  back_code,
    input  logic [3:0]  area_code,
    input  logic [3:0]  kirby_code,
    input  logic [3:0]  star_code,
    input  logic [3:0]  enemy_code,
    input  logic [3:0]  bar_code,
    input  logic [3:0]  start_code,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        pix_valid
);

    localparam int         FADE_SHIFT = $clog2(FADE_FRAMES);
    localparam logic [4:0] B_MAX      = 5'(FADE_FRAMES);

    fade_state_t state_q;
    logic [4:0]  b_q;
    layer_sel_t  sel_q;

    // Fade FSM; the pixel pipeline only ever sees its registered b/sel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= SHOW_START;
            b_q     <= B_MAX;
            sel_q   <= START;
        end else if (frame_tick) begin
            case (state_q)
                SHOW_START, FADE_OUT: begin
                    if (game_start) begin
                        state_q <= SHOW_START;
                        b_q     <= B_MAX;
                        sel_q   <= START;
                    end else if (b_q == 5'd1) begin
                        state_q <= FADE_IN;
                        b_q     <= 5'd0;
                        sel_q   <= GAME;
                    end else begin
                        state_q <= FADE_OUT;
                        b_q     <= b_q - 5'd1;
                        sel_q   <= START;
                    end
                end
                FADE_IN, SHOW_GAME: begin
                    if (game_start) begin
                        state_q <= SHOW_START;
                        b_q     <= B_MAX;
                        sel_q   <= START;
                    end else if (b_q >= B_MAX - 5'd1) begin
                        state_q <= SHOW_GAME;
                        b_q     <= B_MAX;
                        sel_q   <= GAME;
                    end else begin
                        state_q <= FADE_IN;
                        b_q     <= b_q + 5'd1;
                        sel_q   <= GAME;
                    end
                end
                default: begin
                    state_q <= SHOW_START;
                    b_q     <= B_MAX;
                    sel_q   <= START;
                end
            endcase
        end
    end

    pix_flags_t flags_d, flags_q;
    pix_flags_t dly_d [ROM_LAT];
    pix_flags_t dly_q [ROM_LAT];
    pix_flags_t al_s;

    // Stage 0: window test and sprite coverage from the raw indices.
    always_comb begin
        flags_d.in_win    = (DrawX >= WIN_X_MIN) && (DrawX <= WIN_X_MAX) &&
                            (DrawY >= WIN_Y_MIN) && (DrawY <= WIN_Y_MAX);
        flags_d.cov_bar   = (barindex   != 17'd0);
        flags_d.cov_kirby = (kirbyindex != 18'd0);
        flags_d.cov_star  = (starindex  != 17'd0);
        flags_d.cov_enemy = (enemyindex != 18'd0);
        flags_d.sel       = sel_q;
        flags_d.bright    = b_q;
    end

    // Stage 1: ROM addresses and pixel flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            back_addr  <= 17'd0;
            area_addr  <= 18'd0;
            kirby_addr <= 18'd0;
            star_addr  <= 17'd0;
            enemy_addr <= 18'd0;
            bar_addr   <= 17'd0;
            start_addr <= 17'd0;
            flags_q    <= '0;
        end else begin
            back_addr  <= backindex;
            area_addr  <= areaindex;
            kirby_addr <= kirbyindex;
            star_addr  <= starindex;
            enemy_addr <= enemyindex;
            bar_addr   <= barindex;
            start_addr <= gamestartindex;
            flags_q    <= flags_d;
        end
    end

    // Flag delay line feed, matching the ROM read latency.
    always_comb begin
        dly_d[0] = flags_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Flag delay line registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROM_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign al_s = dly_q[ROM_LAT-1];

    logic [3:0]  win_code_s;
    logic        cmp_win_d, cmp_win_q;
    logic [4:0]  cmp_b_d, cmp_b_q;
    logic [23:0] pal_rgb_s;

    // Priority resolution; an uncovered sprite is ignored whatever its ROM returns.
    always_comb begin
        if (al_s.sel == START) begin
            win_code_s = start_code;
        end else if (al_s.cov_bar && (bar_code != 4'd0)) begin
            win_code_s = bar_code;
        end else if (al_s.cov_kirby && (kirby_code != 4'd0)) begin
            win_code_s = kirby_code;
        end else if (al_s.cov_star && (star_code != 4'd0)) begin
            win_code_s = star_code;
        end else if (al_s.cov_enemy && (enemy_code != 4'd0)) begin
            win_code_s = enemy_code;
        end else if (area_code != 4'd0) begin
            win_code_s = area_code;
        end else begin
            win_code_s = back_code;
        end
        cmp_win_d = al_s.in_win;
        cmp_b_d   = al_s.bright;
    end

    palette_lut u_palette_lut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .code    (win_code_s),
        .rgb     (pal_rgb_s)
    );

    // Compose-stage side flags, alongside the palette register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cmp_win_q <= 1'b0;
            cmp_b_q   <= 5'd0;
        end else begin
            cmp_win_q <= cmp_win_d;
            cmp_b_q   <= cmp_b_d;
        end
    end

    logic [7:0] red_d, green_d, blue_d, red_q, green_q, blue_q;
    logic       valid_d, valid_q;

    // Fade scaling and window blanking.
    always_comb begin
        if (cmp_win_q) begin
            red_d   = fade_chan(pal_rgb_s[23:16], cmp_b_q, FADE_SHIFT);
            green_d = fade_chan(pal_rgb_s[15:8],  cmp_b_q, FADE_SHIFT);
            blue_d  = fade_chan(pal_rgb_s[7:0],   cmp_b_q, FADE_SHIFT);
            valid_d = 1'b1;
        end else begin
            red_d   = 8'd0;
            green_d = 8'd0;
            blue_d  = 8'd0;
            valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red_q   <= 8'd0;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            valid_q <= valid_d;
        end
    end

    assign Red       = red_q;
    assign Green     = green_q;
    assign Blue      = blue_q;
    assign pix_valid = valid_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: two instances (ROM_LAT 2 and 4) fed by
// a behavioural sprite ROM whose contents are set per scenario.
module tb_pixel_compositor;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        frame_tick, game_start;
    logic [16:0] backindex, starindex, barindex, gamestartindex;
    logic [17:0] areaindex, kirbyindex, enemyindex;

    logic [16:0] l2_back_addr, l2_star_addr, l2_bar_addr, l2_start_addr;
    logic [17:0] l2_area_addr, l2_kirby_addr, l2_enemy_addr;
    logic [16:0] l4_back_addr, l4_star_addr, l4_bar_addr, l4_start_addr;
    logic [17:0] l4_area_addr, l4_kirby_addr, l4_enemy_addr;
    logic [3:0]  l2_code [7];
    logic [3:0]  l4_code [7];
    logic [7:0]  l2_red, l2_green, l2_blue, l4_red, l4_green, l4_blue;
    logic        l2_valid, l4_valid;

    // ROM layers: 0 back, 1 area, 2 kirby, 3 star, 4 enemy, 5 bar, 6 start
    logic [3:0] rom [7][64];
    logic [5:0] l2_lo [7];
    logic [5:0] l4_lo [7];
    logic [3:0] p2 [7][2];
    logic [3:0] p4 [7][4];

    int n_checks = 0;
    int n_fail   = 0;

    always_comb begin
        l2_lo[0] = l2_back_addr[5:0];  l2_lo[1] = l2_area_addr[5:0];
        l2_lo[2] = l2_kirby_addr[5:0]; l2_lo[3] = l2_star_addr[5:0];
        l2_lo[4] = l2_enemy_addr[5:0]; l2_lo[5] = l2_bar_addr[5:0];
        l2_lo[6] = l2_start_addr[5:0];
        l4_lo[0] = l4_back_addr[5:0];  l4_lo[1] = l4_area_addr[5:0];
        l4_lo[2] = l4_kirby_addr[5:0]; l4_lo[3] = l4_star_addr[5:0];
        l4_lo[4] = l4_enemy_addr[5:0]; l4_lo[5] = l4_bar_addr[5:0];
        l4_lo[6] = l4_start_addr[5:0];
        for (int l = 0; l < 7; l++) begin
            l2_code[l] = p2[l][1];
            l4_code[l] = p4[l][3];
        end
    end

    always @(posedge Clk) begin
        for (int l = 0; l < 7; l++) begin
            p2[l][0] <= rom[l][l2_lo[l]];
            p2[l][1] <= p2[l][0];
            p4[l][0] <= rom[l][l4_lo[l]];
            for (int s = 1; s < 4; s++) p4[l][s] <= p4[l][s-1];
        end
    end

    pixel_compositor #(.ROM_LAT(2), .FADE_FRAMES(8)) dut_l2 (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .frame_tick(frame_tick), .game_start(game_start),
        .backindex(backindex), .areaindex(areaindex), .kirbyindex(kirbyindex),
        .starindex(starindex), .enemyindex(enemyindex), .barindex(barindex),
        .gamestartindex(gamestartindex),
        .back_addr(l2_back_addr), .area_addr(l2_area_addr), .kirby_addr(l2_kirby_addr),
        .star_addr(l2_star_addr), .enemy_addr(l2_enemy_addr), .bar_addr(l2_bar_addr),
        .start_addr(l2_start_addr),
        .back_code(l2_code[0]), .area_code(l2_code[1]), .kirby_code(l2_code[2]),
        .star_code(l2_code[3]), .enemy_code(l2_code[4]), .bar_code(l2_code[5]),
        .start_code(l2_code[6]),
        .Red(l2_red), .Green(l2_green), .Blue(l2_blue), .pix_valid(l2_valid)
    );

    pixel_compositor #(.ROM_LAT(4), .FADE_FRAMES(8)) dut_l4 (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .frame_tick(frame_tick), .game_start(game_start),
        .backindex(backindex), .areaindex(areaindex), .kirbyindex(kirbyindex),
        .starindex(starindex), .enemyindex(enemyindex), .barindex(barindex),
        .gamestartindex(gamestartindex),
        .back_addr(l4_back_addr), .area_addr(l4_area_addr), .kirby_addr(l4_kirby_addr),
        .star_addr(l4_star_addr), .enemy_addr(l4_enemy_addr), .bar_addr(l4_bar_addr),
        .start_addr(l4_start_addr),
        .back_code(l4_code[0]), .area_code(l4_code[1]), .kirby_code(l4_code[2]),
        .star_code(l4_code[3]), .enemy_code(l4_code[4]), .bar_code(l4_code[5]),
        .start_code(l4_code[6]),
        .Red(l4_red), .Green(l4_green), .Blue(l4_blue), .pix_valid(l4_valid)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic clear_indices();
        backindex = 17'd0; areaindex = 18'd0; kirbyindex = 18'd0; starindex = 17'd0;
        enemyindex = 18'd0; barindex = 17'd0; gamestartindex = 17'd0;
    endtask

    // One in-window pixel for one cycle, output read five cycles later.
    task automatic measure(input logic [9:0] x, input logic [9:0] y,
                           output logic [23:0] rgb, output logic v);
        DrawX = x;
        DrawY = y;
        step();
        DrawX = 10'd0;
        DrawY = 10'd0;
        repeat (4) step();
        rgb = {l2_red, l2_green, l2_blue};
        v   = l2_valid;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        DrawX = 10'd300; DrawY = 10'd200;
        backindex = 17'd6; kirbyindex = 18'd40; gamestartindex = 17'd1;
        repeat (4) step();
        n_checks++;
        if ({l2_red, l2_green, l2_blue, l2_valid} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_out: got rgb=%h valid=%b, expected 000000/0",
                     {l2_red, l2_green, l2_blue}, l2_valid);
        end
        n_checks++;
        if ({l2_back_addr, l2_kirby_addr, l2_start_addr, l4_kirby_addr} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got back=%h kirby=%h start=%h, expected 0",
                     l2_back_addr, l2_kirby_addr, l2_start_addr);
        end
        DrawX = 10'd0; DrawY = 10'd0;
        clear_indices();
        Reset_n = 1'b1;
        repeat (3) step();
    endtask

    // Single start-screen pixel: valid exactly at 5 (ROM_LAT 2) and 7 (ROM_LAT 4) cycles.
    task automatic test_start_latency();
        DrawX = 10'd300; DrawY = 10'd200; gamestartindex = 17'd1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) begin
                n_checks++;
                if (l2_start_addr !== 17'd1) begin
                    n_fail++;
                    $display("FAIL start_addr: got %h expected 00001", l2_start_addr);
                end
                DrawX = 10'd0; DrawY = 10'd0; gamestartindex = 17'd0;
            end
            n_checks++;
            if (l2_valid !== (c == 5)) begin
                n_fail++;
                $display("FAIL lat2_valid c=%0d: got %b expected %b", c, l2_valid, c == 5);
            end
            n_checks++;
            if (l4_valid !== (c == 7)) begin
                n_fail++;
                $display("FAIL lat4_valid c=%0d: got %b expected %b", c, l4_valid, c == 7);
            end
            if (c == 5) begin
                n_checks++;
                if ({l2_red, l2_green, l2_blue} !== 24'hFFFF00) begin
                    n_fail++;
                    $display("FAIL lat2_rgb: got %h expected FFFF00", {l2_red, l2_green, l2_blue});
                end
            end
            if (c == 7) begin
                n_checks++;
                if ({l4_red, l4_green, l4_blue} !== 24'hFFFF00) begin
                    n_fail++;
                    $display("FAIL lat4_rgb: got %h expected FFFF00", {l4_red, l4_green, l4_blue});
                end
            end
        end
    endtask

    task automatic test_fade();
        logic [23:0] rgb;
        logic        v;
        logic [23:0] exp_rgb [5];
        int          ticks [5];
        exp_rgb[0] = 24'hDF7038; ticks[0] = 1;   // b=7, start code 9
        exp_rgb[1] = 24'h7F4020; ticks[1] = 3;   // b=4, start code 9
        exp_rgb[2] = 24'h000000; ticks[2] = 4;   // b=0, game layer
        exp_rgb[3] = 24'h7F4020; ticks[3] = 4;   // b=4, back code 9
        exp_rgb[4] = 24'hFF8040; ticks[4] = 4;   // SHOW_GAME, full
        gamestartindex = 17'd2;
        backindex      = 17'd3;
        game_start     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (ticks[k]) tick();
            measure(10'd300, 10'd200, rgb, v);
            n_checks++;
            if ({rgb, v} !== {exp_rgb[k], 1'b1}) begin
                n_fail++;
                $display("FAIL fade_step%0d: got rgb=%h valid=%b, expected %h/1", k, rgb, v, exp_rgb[k]);
            end
        end
        tick();
        measure(10'd300, 10'd200, rgb, v);
        n_checks++;
        if ({rgb, v} !== {24'hFF8040, 1'b1}) begin
            n_fail++;
            $display("FAIL fade_hold: got rgb=%h valid=%b, expected FF8040/1", rgb, v);
        end
        clear_indices();
    endtask

    task automatic test_priority();
        logic [23:0] rgb;
        logic        v;
        logic [23:0] exp_rgb [7];
        logic [17:0] kv [7];
        logic [16:0] bv [7];
        logic [17:0] av [7];
        logic [16:0] sv [7];
        logic [17:0] ev [7];
        kv[0]=18'd40; bv[0]=17'd0; av[0]=18'd5; sv[0]=17'd0;  ev[0]=18'd0; exp_rgb[0]=24'h00FF00;
        kv[1]=18'd41; bv[1]=17'd0; av[1]=18'd5; sv[1]=17'd0;  ev[1]=18'd0; exp_rgb[1]=24'h00FFFF;
        kv[2]=18'd41; bv[2]=17'd0; av[2]=18'd4; sv[2]=17'd0;  ev[2]=18'd0; exp_rgb[2]=24'h804000;
        kv[3]=18'd40; bv[3]=17'd7; av[3]=18'd5; sv[3]=17'd0;  ev[3]=18'd0; exp_rgb[3]=24'hFF0000;
        kv[4]=18'd0;  bv[4]=17'd0; av[4]=18'd5; sv[4]=17'd0;  ev[4]=18'd0; exp_rgb[4]=24'h00FFFF;
        kv[5]=18'd0;  bv[5]=17'd0; av[5]=18'd5; sv[5]=17'd8;  ev[5]=18'd9; exp_rgb[5]=24'h0000FF;
        kv[6]=18'd0;  bv[6]=17'd0; av[6]=18'd5; sv[6]=17'd10; ev[6]=18'd9; exp_rgb[6]=24'hFF00FF;
        backindex = 17'd6;
        for (int k = 0; k < 7; k++) begin
            kirbyindex = kv[k]; barindex = bv[k]; areaindex = av[k];
            starindex = sv[k]; enemyindex = ev[k];
            measure(10'd300, 10'd200, rgb, v);
            n_checks++;
            if ({rgb, v} !== {exp_rgb[k], 1'b1}) begin
                n_fail++;
                $display("FAIL priority%0d: got rgb=%h valid=%b, expected %h/1", k, rgb, v, exp_rgb[k]);
            end
        end
    endtask

    task automatic test_window();
        logic [23:0] rgb;
        logic        v;
        logic [9:0]  xs [7];
        logic [9:0]  ys [7];
        logic        ev [7];
        xs[0]=10'd100; ys[0]=10'd200; ev[0]=1'b0;
        xs[1]=10'd203; ys[1]=10'd152; ev[1]=1'b1;
        xs[2]=10'd435; ys[2]=10'd327; ev[2]=1'b1;
        xs[3]=10'd202; ys[3]=10'd200; ev[3]=1'b0;
        xs[4]=10'd436; ys[4]=10'd200; ev[4]=1'b0;
        xs[5]=10'd300; ys[5]=10'd151; ev[5]=1'b0;
        xs[6]=10'd300; ys[6]=10'd328; ev[6]=1'b0;
        backindex = 17'd6; areaindex = 18'd5; kirbyindex = 18'd40; starindex = 17'd8;
        enemyindex = 18'd9; barindex = 17'd7; gamestartindex = 17'd1;
        for (int k = 0; k < 7; k++) begin
            measure(xs[k], ys[k], rgb, v);
            n_checks++;
            if ({rgb, v} !== (ev[k] ? {24'hFF0000, 1'b1} : 25'd0)) begin
                n_fail++;
                $display("FAIL window x=%0d y=%0d: got rgb=%h valid=%b, expected valid=%b",
                         xs[k], ys[k], rgb, v, ev[k]);
            end
        end
        clear_indices();
    endtask

    // Four pixels on consecutive cycles; each must keep its own flags and codes.
    task automatic test_back_to_back();
        logic [9:0]  xs [4];
        logic [17:0] kv [4];
        logic [16:0] bv [4];
        logic [23:0] exp_rgb [4];
        logic        ev [4];
        xs[0]=10'd300; kv[0]=18'd40; bv[0]=17'd0; exp_rgb[0]=24'h00FF00; ev[0]=1'b1;
        xs[1]=10'd300; kv[1]=18'd0;  bv[1]=17'd0; exp_rgb[1]=24'h00FFFF; ev[1]=1'b1;
        xs[2]=10'd100; kv[2]=18'd40; bv[2]=17'd7; exp_rgb[2]=24'h000000; ev[2]=1'b0;
        xs[3]=10'd300; kv[3]=18'd40; bv[3]=17'd7; exp_rgb[3]=24'hFF0000; ev[3]=1'b1;
        areaindex = 18'd5; backindex = 17'd6; DrawY = 10'd200;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
                DrawX = xs[j]; kirbyindex = kv[j]; barindex = bv[j];
            end else begin
                DrawX = 10'd0; kirbyindex = 18'd0; barindex = 17'd0;
            end
            step();
            if (j >= 4) begin
                n_checks++;
                if ({l2_red, l2_green, l2_blue, l2_valid} !== {exp_rgb[j-4], ev[j-4]}) begin
                    n_fail++;
                    $display("FAIL b2b_pix%0d: got rgb=%h valid=%b, expected %h/%b", j - 4,
                             {l2_red, l2_green, l2_blue}, l2_valid, exp_rgb[j-4], ev[j-4]);
                end
            end
        end
        DrawY = 10'd0;
        clear_indices();
    endtask

    task automatic test_reset_mid_fade();
        logic [23:0] rgb;
        logic        v;
        game_start = 1'b1;
        tick();
        gamestartindex = 17'd1;
        measure(10'd300, 10'd200, rgb, v);
        n_checks++;
        if ({rgb, v} !== {24'hFFFF00, 1'b1}) begin
            n_fail++;
            $display("FAIL game_to_start: got rgb=%h valid=%b, expected FFFF00/1", rgb, v);
        end
        game_start = 1'b0;
        repeat (10) tick();
        backindex = 17'd3;
        DrawX = 10'd300; DrawY = 10'd200;
        repeat (5) step();
        n_checks++;
        if ({l2_red, l2_green, l2_blue, l2_valid} !== {24'h3F2010, 1'b1}) begin
            n_fail++;
            $display("FAIL fade_in_b2: got rgb=%h valid=%b, expected 3F2010/1",
                     {l2_red, l2_green, l2_blue}, l2_valid);
        end
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({l2_red, l2_green, l2_blue, l2_valid, l4_valid} !== 26'd0) begin
            n_fail++;
            $display("FAIL midreset_out: got rgb=%h valid=%b, expected 000000/0",
                     {l2_red, l2_green, l2_blue}, l2_valid);
        end
        step();
        n_checks++;
        if ({l2_valid, l2_back_addr, l2_red} !== 26'd0) begin
            n_fail++;
            $display("FAIL midreset_edge: got valid=%b back_addr=%h red=%h, expected 0",
                     l2_valid, l2_back_addr, l2_red);
        end
        DrawX = 10'd0; DrawY = 10'd0;
        Reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (l2_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flushed c=%0d: got valid=%b expected 0", c, l2_valid);
            end
        end
        measure(10'd300, 10'd200, rgb, v);
        n_checks++;
        if ({rgb, v} !== {24'hFFFF00, 1'b1}) begin
            n_fail++;
            $display("FAIL after_reset_start: got rgb=%h valid=%b, expected FFFF00/1", rgb, v);
        end
    endtask

    initial begin
        for (int l = 0; l < 7; l++) begin
            for (int a = 0; a < 64; a++) rom[l][a] = 4'd0;
        end
        rom[0][3] = 4'd9;  rom[0][6] = 4'd12;
        rom[1][5] = 4'd7;
        rom[2][0] = 4'd3;  rom[2][40] = 4'd3;
        rom[3][8] = 4'd4;
        rom[4][9] = 4'd6;
        rom[5][7] = 4'd2;
        rom[6][1] = 4'd5;  rom[6][2] = 4'd9;
        frame_tick = 1'b0;
        game_start = 1'b1;
        clear_indices();
        test_reset();
        test_start_latency();
        test_fade();
        test_priority();
        test_window();
        test_back_to_back();
        test_reset_mid_fade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
